// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU (port 0) and the loader (port 1).
// Latency: an idle arbiter holds the memory for LATENCY cycles and pulses ack in the cycle after that.
// Backpressure: a requester holds req until its one-cycle ack; stall0 holds the CPU pipeline until then.
module dmem_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int LATENCY       = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0,
  input  logic                     we0,
  input  logic [ADDRESS_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0]    wdata0,
  output logic                     ack0,
  output logic [DATA_WIDTH-1:0]    rdata0,
  output logic                     stall0,
  input  logic                     req1,
  input  logic                     we1,
  input  logic [ADDRESS_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0]    wdata1,
  output logic                     ack1,
  output logic [DATA_WIDTH-1:0]    rdata1,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_a,
  output logic [DATA_WIDTH-1:0]    mem_wd,
  input  logic [DATA_WIDTH-1:0]    mem_rd,
  output logic                     busy
);

  // Counter only needs to hold LATENCY-1; keep at least one bit for LATENCY=1.
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     ack0_q, ack0_d;
  logic                     ack1_q, ack1_d;
  logic [DATA_WIDTH-1:0]    rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0]    rdata1_q, rdata1_d;
  logic                     last_grant_q, last_grant_d;
  logic                     win_q, win_d;
  logic                     we_q, we_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;

  logic mreq0, mreq1;
  logic gnt_vld, gnt_port;

  // Arbitration: in RESP the just-acked port still shows req, so mask it out.
  always_comb begin
    mreq0    = req0 & ~((state_q == RESP) & (win_q == 1'b0));
    mreq1    = req1 & ~((state_q == RESP) & (win_q == 1'b1));
    gnt_vld  = mreq0 | mreq1;
    gnt_port = (mreq0 & mreq1) ? ~last_grant_q : mreq1;
  end

  // Next-state logic: grant/latch payload, count out the access window, pulse ack.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    last_grant_d = last_grant_q;
    win_d        = win_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    case (state_q)
      IDLE, RESP: begin
        if (state_q == RESP) begin
          last_grant_d = win_q;
          state_d      = IDLE;
        end
        if (gnt_vld) begin
          win_d   = gnt_port;
          we_d    = gnt_port ? we1 : we0;
          addr_d  = gnt_port ? addr1 : addr0;
          wdata_d = gnt_port ? wdata1 : wdata0;
          cnt_d   = CW'(LATENCY - 1);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          if (win_q) begin
            ack1_d = 1'b1;
            if (!we_q) rdata1_d = mem_rd;
          end else begin
            ack0_d = 1'b1;
            if (!we_q) rdata0_d = mem_rd;
          end
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any access immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      last_grant_q <= 1'b1;
      win_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      last_grant_q <= last_grant_d;
      win_q        <= win_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  // Memory drive only during ACCESS; the write strobe lands on the final window cycle.
  assign mem_we = (state_q == ACCESS) & we_q & (cnt_q == '0);
  assign mem_a  = (state_q == ACCESS) ? addr_q : '0;
  assign mem_wd = (state_q == ACCESS) ? wdata_q : '0;

  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;
  assign stall0 = req0 & ~ack0_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: LATENCY=2 instance with scoreboard, plus a LATENCY=1 instance.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Each sampled ack pops one expected {port, rdata} entry pushed when the request was driven.
module tb_dmem_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;

  logic clk, rst;

  // LATENCY=2 instance signals
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, stall0, mem_we, busy;
  logic [DW-1:0] rdata0, rdata1, mem_wd, mem_rd;
  logic [AW-1:0] mem_a;

  // LATENCY=1 instance signals
  logic          req0_b, we0_b, req1_b, we1_b;
  logic [AW-1:0] addr0_b, addr1_b;
  logic [DW-1:0] wdata0_b, wdata1_b;
  logic          ack0_b, ack1_b, stall0_b, mem_we_b, busy_b;
  logic [DW-1:0] rdata0_b, rdata1_b, mem_wd_b, mem_rd_b;
  logic [AW-1:0] mem_a_b;

  // Bench memories with a preload port
  logic [DW-1:0] mem   [0:255];
  logic [DW-1:0] mem_b [0:255];
  logic          pl_en, pl_sel;
  logic [AW-1:0] pl_a;
  logic [DW-1:0] pl_d;

  typedef struct packed {
    logic          port;
    logic [DW-1:0] rdata;
  } exp_t;
  exp_t sb_q[$];

  int            n_tests, n_fail;
  logic          held0, held1, we_seen, ack0_seen;
  logic [DW-1:0] exp_rd0, exp_rd1;

  dmem_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .rdata0(rdata0), .stall0(stall0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .rdata1(rdata1),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .busy(busy)
  );

  dmem_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .LATENCY(1)) u_dut_b (
    .clk(clk), .rst(rst),
    .req0(req0_b), .we0(we0_b), .addr0(addr0_b), .wdata0(wdata0_b),
    .ack0(ack0_b), .rdata0(rdata0_b), .stall0(stall0_b),
    .req1(req1_b), .we1(we1_b), .addr1(addr1_b), .wdata1(wdata1_b),
    .ack1(ack1_b), .rdata1(rdata1_b),
    .mem_we(mem_we_b), .mem_a(mem_a_b), .mem_wd(mem_wd_b), .mem_rd(mem_rd_b),
    .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_a] <= mem_wd;
    if (pl_en && !pl_sel) mem[pl_a] <= pl_d;
  end
  always @(posedge clk) begin
    if (mem_we_b) mem_b[mem_a_b] <= mem_wd_b;
    if (pl_en && pl_sel) mem_b[pl_a] <= pl_d;
  end
  assign mem_rd   = mem[mem_a];
  assign mem_rd_b = mem_b[mem_a_b];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic port, input logic [DW-1:0] rd);
    exp_t e;
    e.port  = port;
    e.rdata = rd;
    sb_q.push_back(e);
  endtask

  // Falling-edge sample: scoreboard pop on ack, req-held protocol check, event flags.
  task automatic neg();
    exp_t e;
    @(negedge clk);
    if (ack0 || ack1) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $error("FAIL sb_unexpected_ack observed ack0=%b ack1=%b expected no ack", ack0, ack1);
      end else begin
        e = sb_q.pop_front();
        chk("sb_port", {31'b0, ack1}, {31'b0, e.port});
        chk("sb_rdata", ack1 ? rdata1 : rdata0, e.rdata);
      end
    end
    if (!rst && held0) chk("req0_held_until_ack", {31'b0, req0}, 32'd1);
    if (!rst && held1) chk("req1_held_until_ack", {31'b0, req1}, 32'd1);
    held0 = !rst && req0 && !ack0;
    held1 = !rst && req1 && !ack1;
    if (mem_we) we_seen = 1'b1;
    if (ack0) ack0_seen = 1'b1;
  endtask

  task automatic pos();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic sel, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_sel = sel;
    pl_a   = a;
    pl_d   = d;
    pl_en  = 1'b1;
    pos();
    pl_en  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_rd0 = '0;
    exp_rd1 = '0;
    pos();
    rst = 1'b0;
    pos();
  endtask

  initial begin
    logic s0, s1, got;
    int n0, n1;
    n_tests = 0; n_fail = 0;
    held0 = 0; held1 = 0; we_seen = 0; ack0_seen = 0;
    exp_rd0 = '0; exp_rd1 = '0;
    rst = 1'b1; pl_en = 0; pl_sel = 0; pl_a = '0; pl_d = '0;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    req0_b = 0; we0_b = 0; addr0_b = '0; wdata0_b = '0;
    req1_b = 0; we1_b = 0; addr1_b = '0; wdata1_b = '0;
    pos();

    // Reset state
    neg();
    chk("rst_ack0", {31'b0, ack0}, 32'd0);
    chk("rst_ack1", {31'b0, ack1}, 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_a", {24'b0, mem_a}, 32'd0);
    pos();

    preload(0, 8'h10, 32'hDEADBEEF);
    preload(0, 8'h44, 32'h0BADF00D);
    preload(0, 8'h30, 32'h11111111);
    for (int i = 0; i < 6; i++) preload(0, 8'h40 + 8'(i), 32'hA000_0000 + 32'(i));
    preload(1, 8'h08, 32'hCAFEF00D);
    rst = 1'b0;
    pos();

    // Lone read; address changed after grant must be ignored
    req0 = 1; we0 = 0; addr0 = 8'h10;
    exp_rd0 = 32'hDEADBEEF; push(0, exp_rd0);
    for (int c = 0; c < 6; c++) begin
      neg();
      chk($sformatf("t1_ack0_c%0d", c), {31'b0, ack0}, {31'b0, c == 3});
      chk($sformatf("t1_stall0_c%0d", c), {31'b0, stall0}, {31'b0, c <= 2});
      chk($sformatf("t1_busy_c%0d", c), {31'b0, busy}, {31'b0, c >= 1 && c <= 3});
      pos();
      if (c == 0) addr0 = 8'h44;
      if (c == 3) req0 = 0;
    end
    chk("t1_rdata0_hold", rdata0, 32'hDEADBEEF);

    // Loader write, then CPU read of the written word
    req1 = 1; we1 = 1; addr1 = 8'h20; wdata1 = 32'h12345678;
    push(1, exp_rd1);
    for (int c = 0; c < 5; c++) begin
      neg();
      chk($sformatf("t2_mem_we_c%0d", c), {31'b0, mem_we}, {31'b0, c == 2});
      chk($sformatf("t2_ack1_c%0d", c), {31'b0, ack1}, {31'b0, c == 3});
      if (c == 2) begin
        chk("t2_mem_a", {24'b0, mem_a}, 32'h20);
        chk("t2_mem_wd", mem_wd, 32'h12345678);
      end
      pos();
      if (c == 3) begin req1 = 0; we1 = 0; end
    end
    chk("t2_mem_written", mem[8'h20], 32'h12345678);
    req0 = 1; we0 = 0; addr0 = 8'h20;
    exp_rd0 = 32'h12345678; push(0, exp_rd0);
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      neg();
      if (ack0) got = 1;
      pos();
    end
    req0 = 0;
    chk("t2_ack0_wait", {31'b0, got}, 32'd1);
    chk("t2_rdata1_unchanged", rdata1, 32'd0);

    // Simultaneous requests after reset: port 0 first, port 1 back-to-back
    do_reset();
    req0 = 1; we0 = 0; addr0 = 8'h10;
    req1 = 1; we1 = 0; addr1 = 8'h20;
    exp_rd0 = 32'hDEADBEEF; push(0, exp_rd0);
    exp_rd1 = 32'h12345678; push(1, exp_rd1);
    for (int c = 0; c < 9; c++) begin
      neg();
      chk($sformatf("t3_ack0_c%0d", c), {31'b0, ack0}, {31'b0, c == 3});
      chk($sformatf("t3_ack1_c%0d", c), {31'b0, ack1}, {31'b0, c == 6});
      chk($sformatf("t3_busy_c%0d", c), {31'b0, busy}, {31'b0, c >= 1 && c <= 6});
      pos();
      if (c == 3) req0 = 0;
      if (c == 6) req1 = 0;
    end

    // Continuous contention: grant order must alternate 0,1,0,1,0,1
    req0 = 1; we0 = 0; addr0 = 8'h40;
    req1 = 1; we1 = 0; addr1 = 8'h41;
    for (int i = 0; i < 6; i++) push(i[0], 32'hA000_0000 + 32'(i));
    exp_rd0 = 32'hA000_0004; exp_rd1 = 32'hA000_0005;
    n0 = 0; n1 = 0;
    for (int c = 0; c < 80 && (n0 + n1) < 6; c++) begin
      neg();
      s0 = ack0; s1 = ack1;
      if (s0) n0++;
      if (s1) n1++;
      pos();
      if (s0) begin
        if (n0 == 3) req0 = 0;
        else addr0 = 8'h40 + 8'(2 * n0);
      end
      if (s1) begin
        if (n1 == 3) req1 = 0;
        else addr1 = 8'h41 + 8'(2 * n1);
      end
    end
    chk("t4_ack_count", 32'(n0 + n1), 32'd6);
    neg();
    pos();

    // Reset in the first ACCESS cycle of a write: no strobe, no ack, busy drops at once
    we_seen = 0; ack0_seen = 0;
    req0 = 1; we0 = 1; addr0 = 8'h30; wdata0 = 32'h55AA55AA;
    neg();
    pos();
    chk("t5_busy_before_rst", {31'b0, busy}, 32'd1);
    #2;
    rst = 1; req0 = 0; we0 = 0;
    exp_rd0 = '0; exp_rd1 = '0;
    #1;
    chk("t5_busy_async", {31'b0, busy}, 32'd0);
    chk("t5_mem_we_async", {31'b0, mem_we}, 32'd0);
    chk("t5_ack0_async", {31'b0, ack0}, 32'd0);
    neg();
    pos();
    rst = 0;
    for (int c = 0; c < 5; c++) begin
      neg();
      pos();
    end
    chk("t5_no_mem_we", {31'b0, we_seen}, 32'd0);
    chk("t5_no_ack0", {31'b0, ack0_seen}, 32'd0);
    chk("t5_mem_unchanged", mem[8'h30], 32'h11111111);

    // LATENCY=1 instance: read acks in cycle 2, write strobes in cycle 1
    req0_b = 1; we0_b = 0; addr0_b = 8'h08;
    for (int c = 0; c < 4; c++) begin
      neg();
      chk($sformatf("t6_ack0_c%0d", c), {31'b0, ack0_b}, {31'b0, c == 2});
      if (c == 0) chk("t6_stall0", {31'b0, stall0_b}, 32'd1);
      if (c == 1) chk("t6_busy", {31'b0, busy_b}, 32'd1);
      if (c == 2) chk("t6_rdata0", rdata0_b, 32'hCAFEF00D);
      pos();
      if (c == 2) req0_b = 0;
    end
    req1_b = 1; we1_b = 1; addr1_b = 8'h09; wdata1_b = 32'h00000077;
    for (int c = 0; c < 4; c++) begin
      neg();
      chk($sformatf("t6_mem_we_c%0d", c), {31'b0, mem_we_b}, {31'b0, c == 1});
      chk($sformatf("t6_ack1_c%0d", c), {31'b0, ack1_b}, {31'b0, c == 2});
      pos();
      if (c == 2) begin req1_b = 0; we1_b = 0; end
    end
    chk("t6_mem_written", mem_b[8'h09], 32'h00000077);
    chk("t6_rdata1_unchanged", rdata1_b, 32'd0);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
